// File: rtl/parking_pkg.sv
// Shared definitions for the parking system: FSM state codes, data widths
// and the coin denomination decoder used by both entrance and exit sides.
package parking_pkg;

  localparam int TIME_W     = 16;
  localparam int FARE_W     = 10;
  localparam int PAID_W     = 11;
  localparam int COIN_W     = 2;
  localparam int COIN_VAL_W = 4;
  localparam int STATE_W    = 3;

  // Encodings are shared with the entrance FSM, so they must not be renumbered.
  localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_TICKET = 3'd1;
  localparam logic [STATE_W-1:0] ST_CALC        = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAYING      = 3'd3;
  localparam logic [STATE_W-1:0] ST_OPEN        = 3'd4;
  localparam logic [STATE_W-1:0] ST_TIMEOUT     = 3'd5;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    logic [COIN_VAL_W-1:0] val;
    case (code)
      2'd0:    val = 4'd1;
      2'd1:    val = 4'd2;
      2'd2:    val = 4'd5;
      default: val = 4'd10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/parking_time_base.sv
// Free-running time base: a prescaler divides the clock by TICK_DIV and a
// 16-bit counter advances once per time unit, wrapping modulo 2^16.
module parking_time_base
  import parking_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [TIME_W-1:0] time_now
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [TIME_W-1:0] time_q, time_d;

  always_comb begin
    pre_d  = pre_q + 1'b1;
    time_d = time_q;
    if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      time_d = time_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      time_q <= '0;
    end else begin
      pre_q  <= pre_d;
      time_q <= time_d;
    end
  end

  assign time_now = time_q;

endmodule

// File: rtl/parking_exit_gate.sv
// Exit barrier controller: reads the ticket timestamp, charges a fare by
// elapsed time, collects coins, returns change and opens the gate.
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int RATE        = 5,
  parameter int FARE_MAX    = 1023,
  parameter int TIMEOUT_CYC = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_exit,
  input  logic               ticket_valid,
  input  logic [TIME_W-1:0]  ticket_time,
  input  logic               coin_valid,
  input  logic [COIN_W-1:0]  coin_code,
  output logic [TIME_W-1:0]  time_now,
  output logic               GREEN_LED,
  output logic               RED_LED,
  output logic [STATE_W-1:0] state,
  output logic [FARE_W-1:0]  fare_due,
  output logic [PAID_W-1:0]  paid,
  output logic [FARE_W-1:0]  change,
  output logic               car_exit,
  output logic               coin_reject
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [FARE_W-1:0]  fare_q, fare_d;
  logic [PAID_W-1:0]  paid_q, paid_d;
  logic [FARE_W-1:0]  change_q, change_d;
  logic [TIME_W-1:0]  ticket_q, ticket_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               car_exit_q, car_exit_d;
  logic               coin_reject_q, coin_reject_d;

  logic [TIME_W-1:0]  elapsed;
  logic [31:0]        fare_full;
  logic [FARE_W-1:0]  fare_calc;
  logic [PAID_W-1:0]  coin_sum;

  parking_time_base #(.TICK_DIV(TICK_DIV)) u_time_base (
    .clk      (clk),
    .reset    (reset),
    .time_now (time_now)
  );

  // Fare is computed at 32 bits so long stays saturate instead of wrapping.
  always_comb begin
    elapsed   = time_now - ticket_q;
    fare_full = 32'(RATE) * (32'(elapsed) + 32'd1);
    fare_calc = (fare_full > 32'(FARE_MAX)) ? FARE_W'(FARE_MAX) : FARE_W'(fare_full);
    coin_sum  = paid_q + PAID_W'(coin_value(coin_code));
  end

  always_comb begin
    state_d       = state_q;
    fare_d        = fare_q;
    paid_d        = paid_q;
    change_d      = change_q;
    ticket_d      = ticket_q;
    to_cnt_d      = to_cnt_q;
    car_exit_d    = 1'b0;
    coin_reject_d = coin_valid && (state_q != ST_PAYING);

    case (state_q)
      ST_IDLE: begin
        if (sensor_exit) state_d = ST_WAIT_TICKET;
      end
      ST_WAIT_TICKET: begin
        if (ticket_valid) begin
          ticket_d = ticket_time;
          state_d  = ST_CALC;
        end else if (!sensor_exit) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        fare_d   = fare_calc;
        paid_d   = '0;
        change_d = '0;
        to_cnt_d = '0;
        state_d  = ST_PAYING;
      end
      // A coin takes priority over both timeout expiry and a departing car.
      ST_PAYING: begin
        if (coin_valid) begin
          paid_d   = coin_sum;
          to_cnt_d = '0;
          if (coin_sum >= {1'b0, fare_q}) begin
            change_d = FARE_W'(coin_sum - {1'b0, fare_q});
            state_d  = ST_OPEN;
          end else if (!sensor_exit) begin
            change_d = FARE_W'(coin_sum);
            state_d  = ST_TIMEOUT;
          end
        end else if (!sensor_exit || (to_cnt_q == TO_LAST)) begin
          change_d = FARE_W'(paid_q);
          state_d  = ST_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_OPEN: begin
        if (!sensor_exit) begin
          car_exit_d = 1'b1;
          fare_d     = '0;
          paid_d     = '0;
          change_d   = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_TIMEOUT: begin
        if (!sensor_exit) begin
          fare_d   = '0;
          paid_d   = '0;
          change_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fare_q        <= '0;
      paid_q        <= '0;
      change_q      <= '0;
      ticket_q      <= '0;
      to_cnt_q      <= '0;
      car_exit_q    <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fare_q        <= fare_d;
      paid_q        <= paid_d;
      change_q      <= change_d;
      ticket_q      <= ticket_d;
      to_cnt_q      <= to_cnt_d;
      car_exit_q    <= car_exit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign state       = state_q;
  assign fare_due    = fare_q;
  assign paid        = paid_q;
  assign change      = change_q;
  assign car_exit    = car_exit_q;
  assign coin_reject = coin_reject_q;
  assign GREEN_LED   = (state_q == ST_OPEN);
  assign RED_LED     = (state_q == ST_WAIT_TICKET) || (state_q == ST_CALC) ||
                       (state_q == ST_PAYING) || (state_q == ST_TIMEOUT);

endmodule
